// File: rtl/dcache_nway.sv
// N-way set-associative write-back / write-allocate data cache with 256-bit lines and a per-set round-robin victim pointer.
// Define DCACHE_NWAY_STATS_EN to build the saturating hit/miss counters; without it both counters read 0.
module dcache_nway #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [255:0]      mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - 5 - IDX_W;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_t;
    state_t state, state_nxt;

    logic [255:0]     data_arr  [WAYS][SETS];
    logic [TAG_W-1:0] tag_arr   [WAYS][SETS];
    logic             valid_arr [WAYS][SETS];
    logic             dirty_arr [WAYS][SETS];

    logic [2:0]       offset;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             active;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] rr_cur;
    logic [WAY_W-1:0] victim_sel;
    logic [WAY_W-1:0] victim_q;
    logic             from_ptr_sel;
    logic             from_ptr_q;
    logic             victim_dirty;
    logic             unused_addr_bits;

    assign offset           = p1_addr_i[4:2];
    assign idx              = p1_addr_i[5 +: IDX_W];
    assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign active           = p1_MemRead_i | p1_MemWrite_i;
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // Tag lookup: lowest matching valid way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!hit && valid_arr[w][idx] && (tag_arr[w][idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        victim_sel   = rr_cur;
        from_ptr_sel = 1'b1;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_arr[w][idx]) begin
                victim_sel   = WAY_W'(w);
                from_ptr_sel = 1'b0;
            end
        end
        victim_dirty = valid_arr[victim_sel][idx] & dirty_arr[victim_sel][idx];
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WAY_W-1:0] rr_ptr [SETS];

            assign rr_cur = rr_ptr[idx];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int s = 0; s < int'(SETS); s++) rr_ptr[s] <= '0;
                end else if (state == FILL && from_ptr_q) begin
                    rr_ptr[idx] <= rr_ptr[idx] + WAY_W'(1);
                end
            end
        end else begin : g_no_rr
            assign rr_cur = '0;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            victim_q   <= '0;
            from_ptr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                victim_q   <= victim_sel;
                from_ptr_q <= from_ptr_sel;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state)
            IDLE: begin
                if (active && !hit) state_nxt = victim_dirty ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_arr[victim_q][idx], idx, 5'b0};
                mem_data_o   = data_arr[victim_q][idx];
                if (mem_ack_i) state_nxt = ALLOCATE;
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, idx, 5'b0};
                if (mem_ack_i) state_nxt = FILL;
            end
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line state bits; cleared by reset so an aborted fill leaves nothing valid
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                for (int s = 0; s < int'(SETS); s++) begin
                    valid_arr[w][s] <= 1'b0;
                    dirty_arr[w][s] <= 1'b0;
                end
            end
        end else if (state == ALLOCATE && mem_ack_i) begin
            valid_arr[victim_q][idx] <= 1'b1;
            dirty_arr[victim_q][idx] <= 1'b0;
        end else if (state == IDLE && p1_MemWrite_i && hit) begin
            dirty_arr[hit_way][idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == ALLOCATE && mem_ack_i) begin
            data_arr[victim_q][idx] <= mem_data_i;
            tag_arr[victim_q][idx]  <= req_tag;
        end else if (state == IDLE && p1_MemWrite_i && hit) begin
            data_arr[hit_way][idx][{offset, 5'b0} +: 32] <= p1_data_i;
        end
    end

    assign p1_data_o  = (p1_MemRead_i && hit) ? data_arr[hit_way][idx][{offset, 5'b0} +: 32] : 32'h0;
    assign p1_stall_o = !rst_i && ((active && !hit) || (state != IDLE));

`ifdef DCACHE_NWAY_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic        replay;

    // The first IDLE cycle after FILL is the stalled access completing, not a fresh hit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            replay   <= 1'b0;
        end else begin
            if (state == FILL) replay <= 1'b1;
            else if (state == IDLE) replay <= 1'b0;
            if (state == IDLE && active && hit && !replay && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == IDLE && state_nxt != IDLE && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;
`else
    assign hit_cnt_o  = 32'h0;
    assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway: a line-level reference cache and memory predict CPU responses and memory traffic.
`timescale 1ns/1ps
module tb_dcache_nway;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned SETS   = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = $clog2(SETS);

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [255:0]      mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [255:0]      mem_data_i;
    logic              mem_ack_i;
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;

    always #5 clk = ~clk;

    dcache_nway #(.WAYS(WAYS), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct { bit is_read; logic [31:0] rdata; int stall; } exp_t;
    typedef struct { bit write; logic [31:0] addr; logic [255:0] data; } mem_exp_t;
    exp_t     exp_q[$];
    mem_exp_t mem_q[$];
    int       lat_q[$];

    // Reference model state
    logic [255:0] ref_mem [int unsigned];
    logic [255:0] m_line  [WAYS][SETS];
    bit           m_valid [WAYS][SETS];
    bit           m_dirty [WAYS][SETS];
    int unsigned  m_tag   [WAYS][SETS];
    int unsigned  m_rr    [SETS];
    int unsigned  exp_hits;
    int unsigned  exp_misses;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input int unsigned la);
        if (!ref_mem.exists(la)) begin
            logic [255:0] l;
            for (int i = 0; i < 8; i++) l[i*32 +: 32] = la ^ (32'h9E37_79B9 * 32'(i + 1));
            ref_mem[la] = l;
        end
        return ref_mem[la];
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < int'(WAYS); w++)
            for (int s = 0; s < int'(SETS); s++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
            end
        for (int s = 0; s < int'(SETS); s++) m_rr[s] = 0;
        exp_hits   = 0;
        exp_misses = 0;
        exp_q.delete();
        mem_q.delete();
        lat_q.delete();
    endfunction

    // Predict one access, then drive it and hold until the cache releases the stall
    task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                          input logic [31:0] wdata, input int lr, input int lw);
        int unsigned set  = (addr >> 5) % SETS;
        int unsigned tag  = addr >> (5 + IDX_W);
        int unsigned word = (addr >> 2) % 8;
        int          way  = -1;
        int          stall = 0;
        int          n = 0;
        bit          from_ptr = 0;
        exp_t        e;
        for (int w = 0; w < int'(WAYS); w++)
            if (way < 0 && m_valid[w][set] && m_tag[w][set] == tag) way = w;
        if (way >= 0) begin
            exp_hits++;
        end else begin
            exp_misses++;
            for (int w = 0; w < int'(WAYS); w++)
                if (way < 0 && !m_valid[w][set]) way = w;
            if (way < 0) begin
                way = int'(m_rr[set]);
                from_ptr = 1;
            end
            stall = 2 + lr;
            if (m_valid[way][set] && m_dirty[way][set]) begin
                int unsigned va = (m_tag[way][set] << (5 + IDX_W)) | (set << 5);
                mem_q.push_back('{1'b1, va, m_line[way][set]});
                lat_q.push_back(lw);
                ref_mem[va] = m_line[way][set];
                stall += lw;
            end
            mem_q.push_back('{1'b0, addr & 32'hFFFF_FFE0, 256'h0});
            lat_q.push_back(lr);
            m_line[way][set]  = mem_line(addr & 32'hFFFF_FFE0);
            m_valid[way][set] = 1;
            m_dirty[way][set] = 0;
            m_tag[way][set]   = tag;
            if (from_ptr) m_rr[set] = (m_rr[set] + 1) % WAYS;
        end
        e.is_read = rd;
        e.rdata   = m_line[way][set][word*32 +: 32];
        e.stall   = stall;
        if (wr) begin
            m_line[way][set][word*32 +: 32] = wdata;
            m_dirty[way][set] = 1;
        end
        exp_q.push_back(e);

        @(posedge clk); #1;
        p1_addr_i     = addr;
        p1_data_i     = wdata;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        do begin
            @(negedge clk);
            n++;
        end while (p1_stall_o && n < 200);
        if (p1_stall_o) begin
            vectors++;
            miscompares++;
            $display("FAIL stall_timeout: addr %0h still stalled after %0d cycles", addr, n);
        end
        @(posedge clk); #1;
        p1_MemRead_i  = 0;
        p1_MemWrite_i = 0;
        @(negedge clk);
`ifdef DCACHE_NWAY_STATS_EN
        chk("hit_cnt", 64'(hit_cnt_o), 64'(exp_hits));
        chk("miss_cnt", 64'(miss_cnt_o), 64'(exp_misses));
`else
        chk("hit_cnt", 64'(hit_cnt_o), 64'h0);
        chk("miss_cnt", 64'(miss_cnt_o), 64'h0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        p1_MemRead_i  = 0;
        p1_MemWrite_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Monitor: on each completed CPU access compare data and stall length
    int   stall_run = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst) begin
            stall_run = 0;
        end else if (p1_MemRead_i || p1_MemWrite_i) begin
            if (p1_stall_o) begin
                stall_run++;
            end else begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_completion: addr %0h with no pending expectation", p1_addr_i);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (stall_run != mon_e.stall) begin
                        miscompares++;
                        $display("FAIL stall_cycles: addr %0h got %0d expected %0d", p1_addr_i, stall_run, mon_e.stall);
                    end
                    if (mon_e.is_read) begin
                        vectors++;
                        if (p1_data_o !== mon_e.rdata) begin
                            miscompares++;
                            $display("FAIL read_data: addr %0h got %0h expected %0h", p1_addr_i, p1_data_o, mon_e.rdata);
                        end
                    end
                end
                stall_run = 0;
            end
        end
    end

    // Memory responder: acks after the latency the stimulus chose and checks each transfer
    int       mcnt = 0;
    int       mlat = 1;
    mem_exp_t me;
    always @(negedge clk) begin
        mem_ack_i = 0;
        if (rst) begin
            mcnt = 0;
        end else if (mem_enable_o) begin
            if (mcnt == 0) begin
                if (lat_q.size() != 0) mlat = lat_q.pop_front();
                else mlat = 1;
            end
            mcnt++;
            if (mcnt >= mlat) begin
                mcnt = 0;
                mem_ack_i = 1;
                vectors++;
                if (mem_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_mem_req: addr %0h write %0b", mem_addr_o, mem_write_o);
                end else begin
                    me = mem_q.pop_front();
                    if (mem_write_o !== me.write || mem_addr_o !== me.addr) begin
                        miscompares++;
                        $display("FAIL mem_req: got addr %0h write %0b expected addr %0h write %0b",
                                 mem_addr_o, mem_write_o, me.addr, me.write);
                    end
                    if (me.write) begin
                        vectors++;
                        if (mem_data_o !== me.data) begin
                            miscompares++;
                            $display("FAIL writeback_data: addr %0h got %0h expected %0h", me.addr, mem_data_o, me.data);
                        end
                    end else begin
                        mem_data_i = mem_line(me.addr);
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1;
        p1_addr_i     = 32'h40;
        p1_data_i     = 0;
        p1_MemRead_i  = 1;
        p1_MemWrite_i = 0;
        mem_data_i    = '0;
        mem_ack_i     = 0;
        model_reset();
        #12;
        chk("reset_stall", 64'(p1_stall_o), 64'h0);
        chk("reset_mem_enable", 64'(mem_enable_o), 64'h0);
        chk("reset_mem_write", 64'(mem_write_o), 64'h0);
        chk("reset_hit_cnt", 64'(hit_cnt_o), 64'h0);
        chk("reset_miss_cnt", 64'(miss_cnt_o), 64'h0);
        chk("reset_rdata", 64'(p1_data_o), 64'h0);
        p1_MemRead_i = 0;
        @(posedge clk); #1 rst = 0;

        // Cold read miss with a 10-cycle memory, then write and read hits
        access(32'h40, 1, 0, 0, 10, 0);
        access(32'h40, 0, 1, 32'hDEAD_BEEF, 1, 1);
        access(32'h40, 1, 0, 0, 1, 1);

        // Dirty victim writeback, then round-robin replacement
        access(32'h240, 1, 0, 0, 4, 0);
        access(32'h440, 1, 0, 0, 3, 5);
        access(32'h640, 1, 0, 0, 2, 2);
        access(32'h44,  1, 0, 0, 2, 2);

        // Clean-only round robin from a fresh reset
        do_reset();
        access(32'h40,  1, 0, 0, 2, 1);
        access(32'h240, 1, 0, 0, 2, 1);
        access(32'h440, 1, 0, 0, 3, 1);
        access(32'h640, 1, 0, 0, 1, 1);
        access(32'h240, 1, 0, 0, 1, 1);

        // Simultaneous read and write returns the pre-write word
        access(32'h44, 0, 1, 32'h11, 2, 2);
        access(32'h44, 1, 1, 32'h22, 1, 1);
        access(32'h44, 1, 0, 0, 1, 1);

        // Reset in the third ALLOCATE cycle abandons the fill
        do_reset();
        lat_q.push_back(10);
        @(posedge clk); #1;
        p1_addr_i    = 32'hC40;
        p1_MemRead_i = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("alloc_enable", 64'(mem_enable_o), 64'h1);
        rst = 1;
        #1;
        chk("rst_abort_enable", 64'(mem_enable_o), 64'h0);
        chk("rst_abort_stall", 64'(p1_stall_o), 64'h0);
        p1_MemRead_i = 0;
        model_reset();
        @(posedge clk); #1 rst = 0;
        access(32'hC40, 1, 0, 0, 3, 1);

        // Randomised traffic over a few sets and tags to force conflicts
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            int op;
            a  = (32'($urandom_range(0, 5)) << (5 + IDX_W)) | (32'($urandom_range(0, 3)) << 5)
                 | (32'($urandom_range(0, 7)) << 2);
            op = $urandom_range(0, 2);
            access(a, op != 1, op != 0, $urandom, $urandom_range(1, 6), $urandom_range(1, 6));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        chk("pending_cpu_expectations", 64'(exp_q.size()), 64'h0);
        chk("pending_mem_expectations", 64'(mem_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
DCACHE_NWAY -- requirements
Module: dcache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity (legal values 1, 2, 4).
REQ-002 SHALL have parameter SETS, default 16, sets per way (power of two, at least 2).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL use a fixed 256-bit line (8 words of 32 bits): addr[4:2] is the word offset, the next log2(SETS) bits are the index, and the remaining upper bits are the tag.
REQ-005 SHALL have clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have the CPU-side ports p1_addr_i (in, ADDR_W), p1_data_i (in, 32), p1_MemRead_i (in, 1), p1_MemWrite_i (in, 1), p1_data_o (out, 32) and p1_stall_o (out, 1).
REQ-008 SHALL have the memory-side ports mem_addr_o (out, ADDR_W, line-aligned), mem_data_o (out, 256), mem_enable_o (out, 1), mem_write_o (out, 1), mem_data_i (in, 256) and mem_ack_i (in, 1).
REQ-009 SHALL have the statistics ports hit_cnt_o (out, 32) and miss_cnt_o (out, 32).

Function
REQ-010 SHALL be a write-back, write-allocate cache with valid bit, dirty bit and tag per line, and a log2(WAYS)-bit round-robin victim pointer per set.
REQ-011 SHALL consider a request active when p1_MemRead_i or p1_MemWrite_i is 1, and SHALL define a hit as a valid way in the indexed set whose tag matches.
REQ-012 SHALL drive p1_data_o combinationally, in the same cycle, from the hit way's selected word on a read hit, and SHALL drive 0 otherwise.
REQ-013 SHALL, on a write hit, update that word and set the dirty bit at the next clk_i edge; p1_stall_o SHALL be 0 (zero-wait).
REQ-014 SHALL, when read and write are both asserted, perform the write, with p1_data_o returning the pre-write word.
REQ-015 SHALL implement the FSM states IDLE, WRITEBACK, ALLOCATE and FILL.
REQ-016 SHALL, in IDLE on an active miss, select the first invalid way (lowest index) as victim; if no way is invalid, the victim is the way at the round-robin pointer.
REQ-017 SHALL, from IDLE, go to WRITEBACK if the victim is valid and dirty, and to ALLOCATE otherwise.
REQ-018 SHALL, in WRITEBACK, drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0} and mem_data_o=victim line, and SHALL go to ALLOCATE on the cycle mem_ack_i=1.
REQ-019 SHALL, in ALLOCATE, drive mem_enable_o=1, mem_write_o=0 and mem_addr_o={request tag, index, 5'b0}; on mem_ack_i=1 it SHALL capture mem_data_i into the victim way, set valid=1 and dirty=0, and go to FILL.
REQ-020 SHALL, in FILL, drive mem_enable_o=0, advance the set's round-robin pointer (modulo WAYS) if the victim was taken from the pointer, and return to IDLE; the replayed request then hits.
REQ-021 SHALL hold mem_enable_o and mem_addr_o stable until mem_ack_i is seen, and SHALL ignore mem_ack_i outside WRITEBACK and ALLOCATE.
REQ-022 SHALL drive p1_stall_o=1 whenever (request active and miss) or state is not IDLE.
REQ-023 SHALL give a clean miss 2 cycles plus the memory latency of stall, and a dirty miss additionally one memory write latency.
REQ-024 SHALL require the CPU to hold its address, data and controls stable while p1_stall_o=1; behaviour on changed inputs is undefined.
REQ-025 SHALL, with WAYS=1, have no victim pointer, and the victim SHALL always be way 0.

Reset
REQ-026 SHALL, while rst_i=1, asynchronously clear all valid bits, dirty bits and round-robin pointers, set state to IDLE, and force mem_enable_o=0, mem_write_o=0, p1_stall_o=0 and the counters to 0.
REQ-027 SHALL, on reset during WRITEBACK or ALLOCATE, abandon the transfer immediately and leave no line half-filled.

Configuration
REQ-028 SHALL, with macro DCACHE_NWAY_STATS_EN defined, increment hit_cnt_o once per completed zero-stall access and miss_cnt_o once per IDLE-to-WRITEBACK/ALLOCATE transition, both saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without DCACHE_NWAY_STATS_EN, tie hit_cnt_o and miss_cnt_o to 0 and include no counter logic.

Verification
REQ-030 SHALL cover: after reset, read 0x0000_0040 with a memory ack after 10 cycles -> stall for 12 cycles, then p1_data_o = the memory word, with miss_cnt_o=1.
REQ-031 SHALL cover: write 0xDEADBEEF to 0x40, then read 0x40 -> both zero-stall, read returns 0xDEADBEEF, hit_cnt_o=2.
REQ-032 SHALL cover: WAYS=2, SETS=16, dirty line at 0x40, then fill 0x240 and read 0x440 -> WRITEBACK of line 0x40 with mem_write_o=1, followed by ALLOCATE of 0x440.
REQ-033 SHALL cover: round-robin with ways filled by 0x40 and 0x240 (both clean), then miss on 0x440 -> way 0 replaced and the pointer becomes 1; next miss 0x640 replaces way 1.
REQ-034 SHALL cover: rst_i asserted in the 3rd cycle of ALLOCATE -> mem_enable_o=0 the same cycle, and a subsequent read of that address misses.
REQ-035 SHALL cover: read and write to 0x44 in the same cycle on a hit holding 0x11 -> p1_data_o=0x11, and the next read returns the written value.
